// File: rtl/oled_pkg.sv
// Shared constants for the SSD1306 128x32 frame scheduler: command lists,
// control bytes and the scheduler state encoding.
package oled_pkg;

  localparam int INIT_LEN = 25;
  localparam int WIN_LEN  = 6;

  localparam logic [7:0] CTRL_CMD  = 8'h00;
  localparam logic [7:0] CTRL_DATA = 8'h40;

  localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h02, 8'h81, 8'h8F, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  // Column window 0..127, page window 0..3
  localparam logic [7:0] WIN_CMDS [WIN_LEN] = '{
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03
  };

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    INIT  = 3'd1,
    IDLE  = 3'd2,
    WIN   = 3'd3,
    DATA  = 3'd4,
    FAULT = 3'd5
  } state_t;

  typedef enum logic {
    LIST_INIT = 1'b0,
    LIST_WIN  = 1'b1
  } list_t;

endpackage

// File: rtl/oled_cmd_rom.sv
// Command-list lookup: maps (list, index) to the command byte so the
// scheduler only has to sequence indices.
import oled_pkg::*;

module oled_cmd_rom (
  input  list_t       list_sel,
  input  logic [4:0]  idx,
  output logic [7:0]  data
);

  always_comb begin
    data = 8'h00;
    if (list_sel == LIST_INIT) begin
      if (int'(idx) < INIT_LEN) data = INIT_CMDS[idx];
    end else begin
      if (int'(idx) < WIN_LEN) data = WIN_CMDS[idx[2:0]];
    end
  end

endmodule

// File: rtl/oled_frame_scheduler.sv
// Sequences SSD1306 init and full-frame refresh traffic onto a valid/ready
// byte stream feeding the I2C master; frame bytes come from a sync-read framebuffer.
import oled_pkg::*;

module oled_frame_scheduler #(
  parameter logic [6:0] I2C_ADDR     = 7'h3C,
  parameter int         NUM_COLS     = 128,
  parameter int         NUM_PAGES    = 4,
  parameter int         PWRUP_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_req,
  output logic        busy,
  output logic        init_done,
  output logic        frame_done,
  output logic        err,
  output logic        fb_rd_en,
  output logic [8:0]  fb_addr,
  input  logic [7:0]  fb_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  input  logic        tx_ready,
  input  logic        tx_nack,
  output state_t      state
);

  localparam int               FB_WORDS  = NUM_COLS * NUM_PAGES;
  localparam logic [8:0]       FB_LAST   = 9'(FB_WORDS - 1);
  localparam int               CNT_W     = $clog2(PWRUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [7:0]       ADDR_BYTE = {I2C_ADDR, 1'b0};
  localparam logic [4:0]       INIT_END  = 5'(INIT_LEN + 1);
  localparam logic [4:0]       WIN_END   = 5'(WIN_LEN + 1);

  logic [CNT_W-1:0] cnt;
  logic [4:0]       idx;
  logic             pending;
  logic             fetch_wait;
  logic             tx_valid_q;
  logic             xfer;
  logic [4:0]       idx_next;
  logic [7:0]       rom_data;
  logic [7:0]       next_byte;
  logic             next_last;
  list_t            list_sel;

  // A NACK kills the offered byte in the very cycle it arrives.
  assign tx_valid = tx_valid_q && !tx_nack;
  assign xfer     = tx_valid && tx_ready;
  assign busy     = (state != IDLE);

  assign idx_next = idx + 5'd1;
  assign list_sel = (state == INIT) ? LIST_INIT : LIST_WIN;

  oled_cmd_rom u_rom (
    .list_sel (list_sel),
    .idx      (idx - 5'd1),
    .data     (rom_data)
  );

  // Byte index 0 is the address, 1 the control byte, 2.. the command list.
  always_comb begin
    next_byte = rom_data;
    next_last = 1'b0;
    if (idx == 5'd0) next_byte = CTRL_CMD;
    if (state == INIT && idx_next == INIT_END) next_last = 1'b1;
    if (state == WIN && idx_next == WIN_END) next_last = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PWRUP;
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      fetch_wait <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      fb_rd_en   <= 1'b0;
      fb_addr    <= '0;
      tx_valid_q <= 1'b0;
      tx_data    <= '0;
      tx_last    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      fb_rd_en   <= 1'b0;
      fetch_wait <= 1'b0;
      if (frame_req && (state inside {PWRUP, INIT, WIN, DATA})) pending <= 1'b1;

      unique case (state)
        PWRUP: begin
          if (tx_nack) begin
            err   <= 1'b1;
            state <= FAULT;
          end else if (cnt == CNT_LAST) begin
            state      <= INIT;
            idx        <= '0;
            tx_valid_q <= 1'b1;
            tx_data    <= ADDR_BYTE;
            tx_last    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        INIT, WIN: begin
          if (tx_nack) begin
            tx_valid_q <= 1'b0;
            err        <= 1'b1;
            state      <= (state == INIT) ? FAULT : IDLE;
          end else if (xfer) begin
            if (tx_last) begin
              tx_last <= 1'b0;
              if (state == INIT) begin
                init_done  <= 1'b1;
                tx_valid_q <= 1'b0;
                state      <= IDLE;
              end else begin
                // Data transaction header follows the window without a gap
                state   <= DATA;
                idx     <= '0;
                tx_data <= ADDR_BYTE;
              end
            end else begin
              idx     <= idx_next;
              tx_data <= next_byte;
              tx_last <= next_last;
            end
          end
        end

        IDLE: begin
          if (pending || frame_req) begin
            err        <= 1'b0;
            pending    <= 1'b0;
            state      <= WIN;
            idx        <= '0;
            fb_addr    <= '0;
            tx_valid_q <= 1'b1;
            tx_data    <= ADDR_BYTE;
            tx_last    <= 1'b0;
          end
        end

        DATA: begin
          if (tx_nack) begin
            tx_valid_q <= 1'b0;
            err        <= 1'b1;
            state      <= IDLE;
          end else begin
            if (fb_rd_en) fetch_wait <= 1'b1;
            if (fetch_wait) begin
              tx_valid_q <= 1'b1;
              tx_data    <= fb_data;
              tx_last    <= (fb_addr == FB_LAST);
            end else if (xfer) begin
              if (tx_last) begin
                tx_valid_q <= 1'b0;
                tx_last    <= 1'b0;
                frame_done <= 1'b1;
                state      <= IDLE;
              end else if (idx == 5'd0) begin
                idx     <= 5'd1;
                tx_data <= CTRL_DATA;
              end else if (idx == 5'd1) begin
                idx        <= 5'd2;
                tx_valid_q <= 1'b0;
                fb_rd_en   <= 1'b1;
              end else begin
                tx_valid_q <= 1'b0;
                fb_addr    <= fb_addr + 9'd1;
                fb_rd_en   <= 1'b1;
              end
            end
          end
        end

        FAULT: ;

        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_scheduler.sv
// Bench for oled_frame_scheduler: directed init/frame/NACK scenarios with a
// byte scoreboard fed by the stimulus and drained by a stream monitor.
`timescale 1ns/1ps
module tb_oled_frame_scheduler;
  import oled_pkg::*;

  localparam int PWR_CYC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_req;
  logic        busy;
  logic        init_done;
  logic        frame_done;
  logic        err;
  logic        fb_rd_en;
  logic [8:0]  fb_addr;
  logic [7:0]  fb_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_ready;
  logic        tx_nack;
  state_t      state;

  logic        ready_drv;
  logic        rnd_ready;
  logic        stall_en;

  logic [8:0]  exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          xfer_cnt = 0;
  int          fd_cnt   = 0;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_word  = '0;

  logic [7:0] init_tbl [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h02, 8'h81, 8'h8F, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };
  logic [7:0] win_tbl [8] = '{
    8'h78, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03
  };

  oled_frame_scheduler #(
    .I2C_ADDR     (7'h3C),
    .NUM_COLS     (128),
    .NUM_PAGES    (4),
    .PWRUP_CYCLES (PWR_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_req  (frame_req),
    .busy       (busy),
    .init_done  (init_done),
    .frame_done (frame_done),
    .err        (err),
    .fb_rd_en   (fb_rd_en),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .tx_nack    (tx_nack),
    .state      (state)
  );

  // Clock / framebuffer model / ready generation
  always #5 clk = ~clk;

  always @(posedge clk) fb_data <= fb_rd_en ? fb_addr[7:0] : 8'hEE;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 99) >= 30);
  end

  assign tx_ready = stall_en ? rnd_ready : ready_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [8:0] w;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !tx_nack) begin
        check("stall_valid_hold", 32'(tx_valid), 32'd1);
        check("stall_word_hold", 32'({tx_last, tx_data}), 32'(prev_word));
      end
      if (frame_done) fd_cnt++;
      if (tx_valid && tx_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got last=%0b data=%0h expected no byte", tx_last, tx_data);
        end else begin
          w = exp_q.pop_front();
          check("stream_byte", 32'({tx_last, tx_data}), 32'(w));
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_word  = {tx_last, tx_data};
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h78});
    exp_q.push_back({1'b0, 8'h00});
    for (int i = 0; i < 25; i++) exp_q.push_back({(i == 24), init_tbl[i]});
  endtask

  task automatic push_frame();
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), win_tbl[i]});
    exp_q.push_back({1'b0, 8'h78});
    exp_q.push_back({1'b0, 8'h40});
    for (int i = 0; i < 512; i++) exp_q.push_back({(i == 511), 8'(i)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_fb_rd_en", 32'(fb_rd_en), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_state", 32'(state), 32'(PWRUP));
    rst = 1'b0;
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic wait_init(input int bound);
    int n = 0;
    while (!init_done && n < bound) begin tick(); n++; end
    check("init_done_wait", 32'(init_done), 32'd1);
  endtask

  task automatic wait_fd(input int target, input int bound);
    int n = 0;
    while (fd_cnt < target && n < bound) begin tick(); n++; end
    check("frame_done_wait", 32'(fd_cnt), 32'(target));
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!tx_valid && n < bound) begin tick(); n++; end
    check("tx_valid_wait", 32'(tx_valid), 32'd1);
  endtask

  task automatic wait_state(input state_t s, input int bound);
    int n = 0;
    while (state != s && n < bound) begin tick(); n++; end
    check("state_wait", 32'(state), 32'(s));
  endtask

  task automatic wait_xfers(input int count, input int bound);
    int base = xfer_cnt;
    int n = 0;
    while ((xfer_cnt - base) < count && n < bound) begin tick(); n++; end
    check("xfer_count_wait", 32'(xfer_cnt - base), 32'(count));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int fd0;
    rst = 1'b1;
    frame_req = 1'b0;
    tx_nack = 1'b0;
    ready_drv = 1'b1;
    stall_en = 1'b0;

    // Power-up delay and init stream
    do_reset();
    push_init();
    cyc = 0;
    while (!tx_valid && cyc < 100) begin tick(); cyc++; end
    check("first_valid_cycle", 32'(cyc), 32'(PWR_CYC));
    wait_init(200);
    check("init_queue_empty", 32'(exp_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Single frame, no stalls
    fd0 = fd_cnt;
    push_frame();
    pulse_req();
    wait_fd(fd0 + 1, 3000);
    repeat (10) tick();
    check("frame1_single_done", 32'(fd_cnt), 32'(fd0 + 1));
    check("frame1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("frame1_busy", 32'(busy), 32'd0);
    check("frame1_fb_addr_end", 32'(fb_addr), 32'd511);

    // Frame with random ready stalls
    fd0 = fd_cnt;
    stall_en = 1'b1;
    push_frame();
    pulse_req();
    wait_fd(fd0 + 1, 6000);
    stall_en = 1'b0;
    repeat (5) tick();
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Requests merged during INIT plus one during DATA
    do_reset();
    push_init();
    fd0 = fd_cnt;
    wait_valid(50);
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      tick();
    end
    push_frame();
    wait_state(DATA, 500);
    pulse_req();
    push_frame();
    wait_fd(fd0 + 2, 8000);
    repeat (20) tick();
    check("pending_frames", 32'(fd_cnt), 32'(fd0 + 2));
    check("pending_queue_empty", 32'(exp_q.size()), 32'd0);
    check("pending_busy", 32'(busy), 32'd0);

    // NACK on data byte 100
    push_frame();
    pulse_req();
    wait_xfers(110, 3000);
    ready_drv = 1'b0;
    wait_valid(20);
    check("nack_byte_data", 32'(tx_data), 32'h64);
    check("nack_byte_last", 32'(tx_last), 32'd0);
    fd0 = fd_cnt;
    tx_nack = 1'b1;
    @(negedge clk);
    check("nack_valid_drop", 32'(tx_valid), 32'd0);
    tick();
    tx_nack = 1'b0;
    exp_q.delete();
    ready_drv = 1'b1;
    tick();
    check("nack_err", 32'(err), 32'd1);
    check("nack_state", 32'(state), 32'(IDLE));
    check("nack_busy", 32'(busy), 32'd0);
    repeat (10) tick();
    check("nack_no_frame_done", 32'(fd_cnt), 32'(fd0));
    push_frame();
    pulse_req();
    check("retry_err_cleared", 32'(err), 32'd0);
    wait_fd(fd0 + 1, 3000);
    repeat (5) tick();
    check("retry_queue_empty", 32'(exp_q.size()), 32'd0);

    // NACK during INIT -> FAULT until reset
    do_reset();
    push_init();
    wait_xfers(5, 200);
    ready_drv = 1'b0;
    wait_valid(20);
    tx_nack = 1'b1;
    tick();
    tx_nack = 1'b0;
    exp_q.delete();
    check("fault_state", 32'(state), 32'(FAULT));
    check("fault_busy", 32'(busy), 32'd1);
    check("fault_init_done", 32'(init_done), 32'd0);
    check("fault_err", 32'(err), 32'd1);
    ready_drv = 1'b1;
    pulse_req();
    repeat (30) tick();
    check("fault_hold_state", 32'(state), 32'(FAULT));
    check("fault_hold_valid", 32'(tx_valid), 32'd0);
    do_reset();
    push_init();
    wait_init(200);
    tick();
    check("reinit_queue_empty", 32'(exp_q.size()), 32'd0);
    check("reinit_err", 32'(err), 32'd0);
    check("reinit_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
